// File: rtl/noekeon_stream_core.sv
// Streaming Noekeon encrypt/decrypt engine: ROUNDS_PER_CYCLE unrolled rounds per clock,
// direct/indirect key modes and a first-word fall-through output FIFO.
package noekeon_pkg;
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] t);
        return t ^ rotl(t, 8) ^ rotl(t, 24);
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        t = mix(a0 ^ a2);
        a1 ^= t;
        a3 ^= t;
        {a0, a1, a2, a3} = {a0, a1, a2, a3} ^ k;
        t = mix(a1 ^ a3);
        a0 ^= t;
        a2 ^= t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        a1 ^= ~a3 & ~a2;
        a0 ^= a2 & a1;
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 ^= a0 ^ a1 ^ a3;
        a1 ^= ~a3 & ~a2;
        a0 ^= a2 & a1;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 31), rotl(s[63:32], 27), rotl(s[31:0], 30)};
    endfunction

    // Decrypt walks the encrypt constant sequence backwards.
    function automatic logic [7:0] rc_next(input logic [7:0] c, input logic dec);
        if (dec)
            return c[0] ? (((c ^ 8'h1B) >> 1) | 8'h80) : (c >> 1);
        return (c << 1) ^ (c[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [127:0] noekeon_rnd(input logic [127:0] s, input logic [127:0] k,
                                                 input logic [7:0] c, input logic dec);
        logic [127:0] b;
        b = s;
        if (!dec) b[127:96] ^= {24'h0, c};
        b = theta(b, k);
        if (dec) b[127:96] ^= {24'h0, c};
        return pi2(gamma(pi1(b)));
    endfunction

    function automatic logic [127:0] final_step(input logic [127:0] s, input logic [127:0] k,
                                                input logic [7:0] c, input logic dec);
        logic [127:0] b;
        b = s;
        if (!dec) b[127:96] ^= {24'h0, c};
        b = theta(b, k);
        if (dec) b[127:96] ^= {24'h0, c};
        return b;
    endfunction
endpackage

module noekeon_round
    import noekeon_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic [7:0]   rc_in,
    input  logic         dec,
    output logic [127:0] st_out,
    output logic [7:0]   rc_out
);
    assign st_out = noekeon_rnd(st_in, rk, rc_in, dec);
    assign rc_out = rc_next(rc_in, dec);
endmodule

module noekeon_stream_core
    import noekeon_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int OUT_DEPTH        = 2
) (
    input  logic                               inClk,
    input  logic                               inReset,
    input  logic                               inMode,
    input  logic                               inKeyWr,
    input  logic [127:0]                       inKeyData,
    output logic                               outKeyReady,
    input  logic                               inDataValid,
    output logic                               outDataReady,
    input  logic                               inDecipher,
    input  logic [127:0]                       inDataData,
    output logic                               outValid,
    input  logic                               inReady,
    output logic [127:0]                       outData,
    output logic [$clog2(OUT_DEPTH+1)-1:0]     outLevel
);
    localparam int N     = 16 / ROUNDS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int LVL_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {NOKEY, KEYSETUP, IDLE, RUN, HOLD} state_t;
    state_t state, state_nxt;

    logic [127:0]     st, key, round_key, result, push_data;
    logic [7:0]       rc;
    logic             dec, last, key_wr, accept, pop, push, has_space;
    logic [CNT_W-1:0] cnt;
    logic [ROUNDS_PER_CYCLE:0][127:0] st_chain;
    logic [ROUNDS_PER_CYCLE:0][7:0]   rc_chain;

    logic [127:0]     mem [OUT_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] level;

    // Indirect key setup runs the same engine as an encryption under the null key.
    assign round_key = (state == KEYSETUP) ? '0 : (dec ? theta(key, '0) : key);

    assign st_chain[0] = st;
    assign rc_chain[0] = rc;
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : gen_round
        noekeon_round u_round (
            .st_in  (st_chain[g]),
            .rk     (round_key),
            .rc_in  (rc_chain[g]),
            .dec    (dec),
            .st_out (st_chain[g+1]),
            .rc_out (rc_chain[g+1])
        );
    end

    assign result    = final_step(st_chain[ROUNDS_PER_CYCLE], round_key, rc_chain[ROUNDS_PER_CYCLE], dec);
    assign last      = (cnt == CNT_W'(N - 1));
    assign key_wr    = inKeyWr && (state == NOKEY || state == IDLE);
    assign accept    = (state == IDLE) && inDataValid && !inKeyWr;
    assign pop       = (level != '0) && inReady;
    assign has_space = (level < LVL_W'(OUT_DEPTH)) || pop;
    assign push      = ((state == RUN) && last && has_space) || ((state == HOLD) && has_space);
    assign push_data = (state == HOLD) ? st : result;

    assign outKeyReady  = (state == NOKEY) || (state == IDLE);
    assign outDataReady = (state == IDLE);
    assign outValid     = (level != '0);
    assign outData      = (level != '0) ? mem[rd_ptr] : '0;
    assign outLevel     = level;

    always_comb begin
        state_nxt = state;
        case (state)
            NOKEY, IDLE: begin
                if (key_wr)      state_nxt = inMode ? KEYSETUP : IDLE;
                else if (accept) state_nxt = RUN;
            end
            KEYSETUP: if (last) state_nxt = IDLE;
            RUN:      if (last) state_nxt = has_space ? IDLE : HOLD;
            HOLD:     if (has_space) state_nxt = IDLE;
            default:  state_nxt = NOKEY;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state <= NOKEY;
            key   <= '0;
            st    <= '0;
            rc    <= '0;
            dec   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (key_wr) begin
                if (!inMode) begin
                    key <= inKeyData;
                end else begin
                    st  <= inKeyData;
                    rc  <= 8'h80;
                    dec <= 1'b0;
                    cnt <= '0;
                end
            end else if (accept) begin
                st  <= inDataData;
                dec <= inDecipher;
                rc  <= inDecipher ? 8'hD4 : 8'h80;
                cnt <= '0;
            end else if (state == RUN || state == KEYSETUP) begin
                st  <= st_chain[ROUNDS_PER_CYCLE];
                rc  <= rc_chain[ROUNDS_PER_CYCLE];
                cnt <= cnt + 1'b1;
                // The finished block parks in st so HOLD can push it later.
                if (last) begin
                    if (state == KEYSETUP) key <= result;
                    else                   st  <= result;
                end
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_noekeon_stream_core.sv
// Directed bench for noekeon_stream_core: reference vectors, round trip, key modes,
// FIFO stall, simultaneous events and mid-run reset across 1/4/16 rounds per cycle.
module tb_noekeon_stream_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, mode, key_wr, data_valid, decipher, ready;
    logic [127:0] key_data, data_in;
    logic         key_ready, data_ready, out_valid;
    logic [127:0] out_data;
    logic [1:0]   out_level;
    logic         key_ready_4, data_ready_4, out_valid_4;
    logic [127:0] out_data_4;
    logic [1:0]   out_level_4;
    logic         key_ready_16, data_ready_16, out_valid_16;
    logic [127:0] out_data_16;
    logic [1:0]   out_level_16;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] C0   = 128'hb1656851_699e29fa_24b70148_503d2dfc;
    localparam logic [127:0] C1   = 128'h2a78421b_87c7d092_4f26113f_1d1349b2;
    localparam logic [127:0] ONES = {128{1'b1}};

    noekeon_stream_core #(.ROUNDS_PER_CYCLE(1), .OUT_DEPTH(2)) dut (
        .inClk(clk), .inReset(rst), .inMode(mode), .inKeyWr(key_wr), .inKeyData(key_data),
        .outKeyReady(key_ready), .inDataValid(data_valid), .outDataReady(data_ready),
        .inDecipher(decipher), .inDataData(data_in), .outValid(out_valid), .inReady(ready),
        .outData(out_data), .outLevel(out_level));

    noekeon_stream_core #(.ROUNDS_PER_CYCLE(4), .OUT_DEPTH(2)) dut4 (
        .inClk(clk), .inReset(rst), .inMode(mode), .inKeyWr(key_wr), .inKeyData(key_data),
        .outKeyReady(key_ready_4), .inDataValid(data_valid), .outDataReady(data_ready_4),
        .inDecipher(decipher), .inDataData(data_in), .outValid(out_valid_4), .inReady(ready),
        .outData(out_data_4), .outLevel(out_level_4));

    noekeon_stream_core #(.ROUNDS_PER_CYCLE(16), .OUT_DEPTH(2)) dut16 (
        .inClk(clk), .inReset(rst), .inMode(mode), .inKeyWr(key_wr), .inKeyData(key_data),
        .outKeyReady(key_ready_16), .inDataValid(data_valid), .outDataReady(data_ready_16),
        .inDecipher(decipher), .inDataData(data_in), .outValid(out_valid_16), .inReady(ready),
        .outData(out_data_16), .outLevel(out_level_16));

    // Word-level reference encryption, used where no published vector exists.
    function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0] a [4];
        logic [31:0] kk [4];
        logic [31:0] t, tmp;
        logic [7:0]  c;
        for (int i = 0; i < 4; i++) begin
            a[i]  = p[127-32*i -: 32];
            kk[i] = k[127-32*i -: 32];
        end
        c = 8'h80;
        for (int r = 0; r <= 16; r++) begin
            a[0] ^= {24'h0, c};
            t = a[0] ^ a[2]; t = t ^ {t[23:0], t[31:24]} ^ {t[7:0], t[31:8]};
            a[1] ^= t; a[3] ^= t;
            for (int i = 0; i < 4; i++) a[i] ^= kk[i];
            t = a[1] ^ a[3]; t = t ^ {t[23:0], t[31:24]} ^ {t[7:0], t[31:8]};
            a[0] ^= t; a[2] ^= t;
            if (r == 16) break;
            a[1] = {a[1][30:0], a[1][31]}; a[2] = {a[2][26:0], a[2][31:27]}; a[3] = {a[3][29:0], a[3][31:30]};
            a[1] ^= ~a[3] & ~a[2];
            a[0] ^= a[2] & a[1];
            tmp = a[3]; a[3] = a[0]; a[0] = tmp;
            a[2] ^= a[0] ^ a[1] ^ a[3];
            a[1] ^= ~a[3] & ~a[2];
            a[0] ^= a[2] & a[1];
            a[1] = {a[1][0], a[1][31:1]}; a[2] = {a[2][4:0], a[2][31:5]}; a[3] = {a[3][1:0], a[3][31:2]};
            c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1B : 8'h00);
        end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1; tick; rst = 1'b0; tick;
    endtask

    task automatic load_key(input logic [127:0] k, input logic m);
        key_wr = 1'b1; key_data = k; mode = m;
        tick;
        key_wr = 1'b0; mode = 1'b0;
    endtask

    // Accepts one block on the main DUT, reports latency (-1 on timeout), head data and
    // outDataReady in the push cycle, then pops the head.
    task automatic do_block(input logic [127:0] p, input logic d, output logic [127:0] res,
                            output int lat, output logic dr);
        data_valid = 1'b1; data_in = p; decipher = d;
        tick;
        data_valid = 1'b0;
        lat = -1; res = '0; dr = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (out_valid) begin lat = i; res = out_data; dr = data_ready; break; end
        end
        ready = 1'b1; tick; ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick; rst = 1'b0;
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL reset_key_ready got %0b want 1", key_ready); end
        tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL reset_data_ready got %0b want 0", data_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests++; if (out_level !== 2'd0) begin fails++; $display("FAIL reset_out_level got %0d want 0", out_level); end
    endtask

    task automatic test_encrypt;
        logic [127:0] res; int lat; logic dr;
        load_key('0, 1'b0);
        tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL direct_key_idle got %0b want 1", data_ready); end
        do_block('0, 1'b0, res, lat, dr);
        tests++; if (lat != 16) begin fails++; $display("FAIL enc0_latency got %0d want 16", lat); end
        tests++; if (res !== C0) begin fails++; $display("FAIL enc0_data got %h want %h", res, C0); end
        tests++; if (dr !== 1'b1) begin fails++; $display("FAIL enc0_ready_after_push got %0b want 1", dr); end
        tests++; if (out_level !== 2'd0) begin fails++; $display("FAIL enc0_level_after_pop got %0d want 0", out_level); end
        load_key(ONES, 1'b0);
        do_block(ONES, 1'b0, res, lat, dr);
        tests++; if (res !== C1) begin fails++; $display("FAIL enc1_data got %h want %h", res, C1); end
    endtask

    task automatic test_decrypt;
        logic [127:0] res; int lat; logic dr;
        load_key('0, 1'b0);
        do_block(C0, 1'b1, res, lat, dr);
        tests++; if (res !== '0) begin fails++; $display("FAIL dec0_data got %h want 0", res); end
        tests++; if (lat != 16) begin fails++; $display("FAIL dec0_latency got %0d want 16", lat); end
        load_key(ONES, 1'b0);
        do_block(C1, 1'b1, res, lat, dr);
        tests++; if (res !== ONES) begin fails++; $display("FAIL dec1_data got %h want %h", res, ONES); end
    endtask

    task automatic test_rpc;
        logic [127:0] tk [4];
        logic [127:0] tp [4];
        logic [127:0] te [4];
        logic         td [4];
        logic [127:0] r4, r16;
        int l4, l16;
        tk = '{'0, '0, ONES, ONES};
        tp = '{'0, C0, ONES, C1};
        te = '{C0, '0, C1, ONES};
        td = '{1'b0, 1'b1, 1'b0, 1'b1};
        pulse_reset;
        for (int v = 0; v < 4; v++) begin
            load_key(tk[v], 1'b0);
            data_valid = 1'b1; data_in = tp[v]; decipher = td[v];
            tick;
            data_valid = 1'b0;
            l4 = -1; l16 = -1; r4 = '0; r16 = '0;
            for (int i = 1; i <= 20; i++) begin
                tick;
                if (l4 < 0 && out_valid_4) begin l4 = i; r4 = out_data_4; end
                if (l16 < 0 && out_valid_16) begin l16 = i; r16 = out_data_16; end
            end
            ready = 1'b1; tick; ready = 1'b0;
            tests++; if (l4 != 4) begin fails++; $display("FAIL rpc4_latency[%0d] got %0d want 4", v, l4); end
            tests++; if (r4 !== te[v]) begin fails++; $display("FAIL rpc4_data[%0d] got %h want %h", v, r4, te[v]); end
            tests++; if (l16 != 1) begin fails++; $display("FAIL rpc16_latency[%0d] got %0d want 1", v, l16); end
            tests++; if (r16 !== te[v]) begin fails++; $display("FAIL rpc16_data[%0d] got %h want %h", v, r16, te[v]); end
        end
    endtask

    task automatic test_indirect;
        logic [127:0] res, exp_res; int lat; logic dr;
        int l1, l4, l16;
        pulse_reset;
        load_key('0, 1'b1);
        l1 = -1; l4 = -1; l16 = -1;
        for (int i = 0; i <= 40; i++) begin
            if (l1 < 0 && key_ready) l1 = i;
            if (l4 < 0 && key_ready_4) l4 = i;
            if (l16 < 0 && key_ready_16) l16 = i;
            if (l1 >= 0 && l4 >= 0 && l16 >= 0) break;
            tick;
        end
        tests++; if (l1 != 16) begin fails++; $display("FAIL indirect_setup_rpc1 got %0d want 16", l1); end
        tests++; if (l4 != 4) begin fails++; $display("FAIL indirect_setup_rpc4 got %0d want 4", l4); end
        tests++; if (l16 != 1) begin fails++; $display("FAIL indirect_setup_rpc16 got %0d want 1", l16); end
        exp_res = ref_enc(C0, '0);
        do_block('0, 1'b0, res, lat, dr);
        tests++; if (res !== exp_res) begin fails++; $display("FAIL indirect_enc got %h want %h", res, exp_res); end
    endtask

    task automatic test_fifo_stall;
        logic [127:0] bp [3];
        logic         bd [3];
        logic [127:0] be [3];
        logic ok;
        bp = '{'0, C0, 128'h1};
        bd = '{1'b0, 1'b1, 1'b0};
        be = '{C0, '0, ref_enc('0, 128'h1)};
        pulse_reset;
        load_key('0, 1'b0);
        ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (data_ready) begin ok = 1'b1; break; end
                tick;
            end
            tests++; if (!ok) begin fails++; $display("FAIL stall_wait_ready[%0d] got timeout want ready", b); end
            data_valid = 1'b1; data_in = bp[b]; decipher = bd[b];
            tick;
            data_valid = 1'b0;
        end
        repeat (20) tick;
        tests++; if (out_level !== 2'd2) begin fails++; $display("FAIL stall_level got %0d want 2", out_level); end
        tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL stall_hold_data_ready got %0b want 0", data_ready); end
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL stall_hold_key_ready got %0b want 0", key_ready); end
        tests++; if (out_data !== be[0]) begin fails++; $display("FAIL stall_head0 got %h want %h", out_data, be[0]); end
        ready = 1'b1; tick; ready = 1'b0;
        tests++; if (out_level !== 2'd2) begin fails++; $display("FAIL stall_pushpop_level got %0d want 2", out_level); end
        tests++; if (out_data !== be[1]) begin fails++; $display("FAIL stall_head1 got %h want %h", out_data, be[1]); end
        tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %0b want 1", data_ready); end
        ready = 1'b1; tick;
        tests++; if (out_data !== be[2]) begin fails++; $display("FAIL stall_head2 got %h want %h", out_data, be[2]); end
        tick; ready = 1'b0;
        tests++; if (out_level !== 2'd0) begin fails++; $display("FAIL stall_drain_level got %0d want 0", out_level); end
    endtask

    task automatic test_simultaneous;
        logic [127:0] res; int lat; logic dr;
        pulse_reset;
        load_key(ONES, 1'b0);
        key_wr = 1'b1; key_data = '0; mode = 1'b0;
        data_valid = 1'b1; data_in = ONES; decipher = 1'b0;
        tick;
        key_wr = 1'b0; data_valid = 1'b0;
        tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL keywin_not_accepted got %0b want 1", data_ready); end
        repeat (20) tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL keywin_no_output got %0b want 0", out_valid); end
        do_block('0, 1'b0, res, lat, dr);
        tests++; if (res !== C0) begin fails++; $display("FAIL keywin_new_key got %h want %h", res, C0); end
        data_valid = 1'b1; data_in = '0; decipher = 1'b0;
        tick;
        data_valid = 1'b0;
        tick; tick;
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL run_key_ready got %0b want 0", key_ready); end
        key_wr = 1'b1; key_data = ONES; mode = 1'b0;
        tick;
        key_wr = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin lat = i; break; end
            tick;
        end
        tests++; if (lat < 0 || out_data !== C0) begin fails++; $display("FAIL run_keywr_ignored got %h want %h", out_data, C0); end
        ready = 1'b1; tick; ready = 1'b0;
    endtask

    task automatic test_reset_midrun;
        pulse_reset;
        load_key('0, 1'b0);
        data_valid = 1'b1; data_in = '0; decipher = 1'b0;
        tick;
        data_valid = 1'b0;
        tick; tick;
        rst = 1'b1; tick;
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL midrst_key_ready got %0b want 1", key_ready); end
        tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL midrst_data_ready got %0b want 0", data_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL midrst_out_data got %h want 0", out_data); end
        tests++; if (out_level !== 2'd0) begin fails++; $display("FAIL midrst_out_level got %0d want 0", out_level); end
        rst = 1'b0;
        repeat (20) tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale_output got %0b want 0", out_valid); end
        tests++; if (data_ready !== 1'b0 || key_ready !== 1'b1) begin fails++; $display("FAIL midrst_nokey got dr=%0b kr=%0b want dr=0 kr=1", data_ready, key_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; key_wr = 1'b0; data_valid = 1'b0; decipher = 1'b0; ready = 1'b0;
        key_data = '0; data_in = '0;
        test_reset;
        test_encrypt;
        test_decrypt;
        test_rpc;
        test_indirect;
        test_fifo_stall;
        test_simultaneous;
        test_reset_midrun;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
